// File: rtl/uart_receiver.sv
// UART byte receiver: synchronises the serial line, samples each bit mid-period
// and hands completed bytes to the consumer with a valid/ack handshake.
module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rec_en,
  input  logic [15:0] comp,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RECEIVE = 2'd2,
    STOP    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [15:0]            comp_c;
  logic [15:0]            comp_int;
  logic [15:0]            half_m1;
  logic [15:0]            full_m1;
  logic [3:0]             bit_c;
  logic [7:0]             shift;
  logic                   sample;
  logic                   start_frame;
  logic                   wr_en;

  // Line idles high, so the chain resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], uart_rx};
    end
  end

  assign rx_s    = sync[SYNC_STAGES-1];
  assign half_m1 = (comp_int >> 1) - 16'd1;
  assign full_m1 = comp_int - 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    sample      = 1'b0;
    start_frame = 1'b0;
    wr_en       = 1'b0;
    case (state)
      IDLE: begin
        if (rec_en && !rx_s) begin
          state_next  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (comp_c == half_m1) begin
          sample     = 1'b1;
          state_next = rx_s ? IDLE : RECEIVE;
        end
      end
      RECEIVE: begin
        if (comp_c == full_m1) begin
          sample = 1'b1;
          if (bit_c == 4'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (comp_c == full_m1) begin
          sample     = 1'b1;
          wr_en      = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
    // Disabling mid-frame drops the partial byte without touching the outputs.
    if (state != IDLE && !rec_en) begin
      state_next = IDLE;
      sample     = 1'b0;
      wr_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comp_c    <= '0;
      comp_int  <= '0;
      bit_c     <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state_next != state || sample) begin
        comp_c <= '0;
      end else begin
        comp_c <= comp_c + 16'd1;
      end

      if (start_frame) begin
        comp_int <= (comp < 16'd4) ? 16'd4 : comp;
        bit_c    <= '0;
      end

      if (sample && state == RECEIVE) begin
        shift <= {rx_s, shift[7:1]};
        bit_c <= bit_c + 4'd1;
      end

      // A byte write takes priority over an ack in the same cycle; an ack that
      // lands together with the write means the old byte was consumed in time.
      if (wr_en) begin
        rx_data   <= shift;
        rx_valid  <= 1'b1;
        frame_err <= !rx_s;
        overrun   <= rx_valid && !rx_ack;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
